// File: rtl/aes_spi_ctrl.sv
// -----------------------------------------------------------------------------
// aes_spi_ctrl
// SPI-slave (mode 0) front end that sequences the AES core over a byte-command
// protocol. An external master loads a key (cmd 0x01), loads a plaintext block
// and starts the core (cmd 0x02), and reads back the result (cmd 0x03).
// All SPI pins are resynchronised into the i_clk domain, so i_clk must run at
// least 8x faster than i_spi_sclk.
//
// Ports:
//   i_clk            system clock
//   i_rst            synchronous active-high reset
//   i_spi_sclk       SPI clock (CPOL=0, CPHA=0), asynchronous to i_clk
//   i_spi_cs_n       SPI chip select, active low
//   i_spi_mosi       SPI data in, MSB first
//   o_spi_miso       SPI data out, MSB first, 0 when not transmitting
//   o_aes_key        key presented to the AES core
//   o_aes_din        plaintext presented to the AES core
//   o_aes_start      one-clk start pulse to the AES core
//   i_aes_done       one-clk completion pulse from the AES core
//   i_aes_dout       AES result, valid while i_aes_done is high
//   o_busy           high from o_aes_start until i_aes_done
//   o_result_valid   result register holds an unread result
//   o_err            one-clk pulse on any protocol error
// -----------------------------------------------------------------------------
module aes_spi_ctrl #(
   parameter int DATA_W      = 128,
   parameter int CMD_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_spi_sclk,
   input  logic              i_spi_cs_n,
   input  logic              i_spi_mosi,
   output logic              o_spi_miso,
   output logic [DATA_W-1:0] o_aes_key,
   output logic [DATA_W-1:0] o_aes_din,
   output logic              o_aes_start,
   input  logic              i_aes_done,
   input  logic [DATA_W-1:0] i_aes_dout,
   output logic              o_busy,
   output logic              o_result_valid,
   output logic              o_err
);

   localparam int                CNT_W     = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(CMD_W - 1);
   localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CMD_W-1:0]  CMD_KEY   = CMD_W'(1);
   localparam logic [CMD_W-1:0]  CMD_START = CMD_W'(2);
   localparam logic [CMD_W-1:0]  CMD_READ  = CMD_W'(3);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_RX, S_TX, S_DRAIN} state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sclk_d;
   logic                   r_cs_d;
   logic [CNT_W-1:0]       r_bit_cnt;
   logic [CMD_W-1:0]       r_cmd;
   logic [DATA_W-1:0]      r_shift;
   logic [DATA_W-1:0]      r_result;
   logic [DATA_W-1:0]      r_aes_key;
   logic [DATA_W-1:0]      r_aes_din;
   logic [DATA_W-1:0]      r_key_pend;
   logic                   r_key_pend_vld;
   logic                   r_key_loaded;
   logic                   r_tx_first;
   logic                   r_miso;
   logic                   r_aes_start;
   logic                   r_busy;
   logic                   r_result_valid;
   logic                   r_err;

   logic                   w_sclk;
   logic                   w_cs_n;
   logic                   w_mosi;
   logic                   w_sclk_rise;
   logic                   w_sclk_fall;
   logic                   w_cs_fall;
   logic [CMD_W-1:0]       w_cmd_next;
   logic [DATA_W-1:0]      w_shift_next;

   assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_n       = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise  = w_sclk & ~r_sclk_d;
   assign w_sclk_fall  = ~w_sclk & r_sclk_d;
   // Synchroniser resets to 0, so a master still holding cs_n low across a
   // reset produces no falling edge and must re-select first.
   assign w_cs_fall    = r_cs_d & ~w_cs_n;
   assign w_cmd_next   = {r_cmd[CMD_W-2:0], w_mosi};
   assign w_shift_next = {r_shift[DATA_W-2:0], w_mosi};

   assign o_spi_miso     = r_miso;
   assign o_aes_key      = r_aes_key;
   assign o_aes_din      = r_aes_din;
   assign o_aes_start    = r_aes_start;
   assign o_busy         = r_busy;
   assign o_result_valid = r_result_valid;
   assign o_err          = r_err;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= S_IDLE;
         r_sclk_sync    <= '0;
         r_cs_sync      <= '0;
         r_mosi_sync    <= '0;
         r_sclk_d       <= 1'b0;
         r_cs_d         <= 1'b0;
         r_bit_cnt      <= '0;
         r_cmd          <= '0;
         r_shift        <= '0;
         r_result       <= '0;
         r_aes_key      <= '0;
         r_aes_din      <= '0;
         r_key_pend     <= '0;
         r_key_pend_vld <= 1'b0;
         r_key_loaded   <= 1'b0;
         r_tx_first     <= 1'b0;
         r_miso         <= 1'b0;
         r_aes_start    <= 1'b0;
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
         r_sclk_d    <= w_sclk;
         r_cs_d      <= w_cs_n;
         r_aes_start <= 1'b0;
         r_err       <= 1'b0;

         // Core completion; a stray done while idle is ignored.
         if (i_aes_done && r_busy) begin
            r_result       <= i_aes_dout;
            r_result_valid <= 1'b1;
            r_busy         <= 1'b0;
         end

         // A key received while the core was running lands once it is idle,
         // i.e. the cycle after aes_done, so the core never sees it change.
         if (r_key_pend_vld && !r_busy) begin
            r_aes_key      <= r_key_pend;
            r_key_pend_vld <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               r_miso <= 1'b0;
               if (w_cs_fall) begin
                  r_state   <= S_CMD;
                  r_bit_cnt <= '0;
               end
            end

            S_CMD: begin
               if (w_cs_n) begin
                  r_state <= S_IDLE;
               end else if (w_sclk_rise) begin
                  r_cmd     <= w_cmd_next;
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  if (r_bit_cnt == CMD_LAST) begin
                     r_bit_cnt  <= '0;
                     r_tx_first <= 1'b1;
                     case (w_cmd_next)
                        CMD_KEY: r_state <= S_RX;
                        CMD_START: begin
                           if (!r_busy && r_key_loaded) begin
                              r_state <= S_RX;
                           end else begin
                              r_err   <= 1'b1;
                              r_state <= S_DRAIN;
                           end
                        end
                        CMD_READ: begin
                           if (r_result_valid) begin
                              r_state <= S_TX;
                           end else begin
                              r_err   <= 1'b1;
                              r_state <= S_DRAIN;
                           end
                        end
                        default: begin
                           r_err   <= 1'b1;
                           r_state <= S_DRAIN;
                        end
                     endcase
                  end
               end
            end

            S_RX: begin
               if (w_cs_n) begin
                  r_state <= S_IDLE;
               end else if (w_sclk_rise) begin
                  r_shift   <= w_shift_next;
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  if (r_bit_cnt == DATA_LAST) begin
                     r_state <= S_DRAIN;
                     if (r_cmd == CMD_KEY) begin
                        r_key_loaded <= 1'b1;
                        if (r_busy) begin
                           r_key_pend     <= w_shift_next;
                           r_key_pend_vld <= 1'b1;
                        end else begin
                           r_aes_key <= w_shift_next;
                        end
                     end else begin
                        r_aes_din      <= w_shift_next;
                        r_aes_start    <= 1'b1;
                        r_busy         <= 1'b1;
                        r_result_valid <= 1'b0;
                     end
                  end
               end
            end

            S_TX: begin
               if (w_cs_n) begin
                  r_state <= S_IDLE;
                  r_miso  <= 1'b0;
               end else begin
                  // Mode 0: drive on falling edge, master samples on rising.
                  if (w_sclk_fall) begin
                     r_tx_first <= 1'b0;
                     if (r_tx_first) begin
                        r_shift <= r_result;
                        r_miso  <= r_result[DATA_W-1];
                     end else begin
                        r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                        r_miso  <= r_shift[DATA_W-2];
                     end
                  end
                  if (w_sclk_rise) begin
                     r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                     if (r_bit_cnt == DATA_LAST) begin
                        r_result_valid <= 1'b0;
                        r_state        <= S_DRAIN;
                     end
                  end
               end
            end

            S_DRAIN: begin
               r_miso <= 1'b0;
               if (w_cs_n) r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
